dmem_responder: RTL and testbench

//  Memory-side responder for the CPU data port. Answers the MEM-stage interface
//  (byte address, 4-bit byte-lane write enable, write data, read data) from an

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Memory-side responder for the CPU data port. Accepts one MEM-stage
//            access at a time, serves it from an internal word array after a
//            fixed LATENCY, and stalls the pipeline (busy) until it completes.
// Ports    : clk        - clock, all state on rising edge
//            rst        - synchronous reset, active-low
//            req_en     - access request, held until busy=0
//            req_addr   - byte address; [ADDR_W+1:2] selects the word
//            req_we     - byte-lane write enable, 0000 = read
//            req_wdata  - lane-aligned write data
//            rdata      - read data, valid with resp_valid on a read
//            resp_valid - one-cycle completion pulse
//            busy       - stall to pipeline (combinational)
//            addr_err   - illegal lane pattern flag
// Config   : DMEM_ALIGN_CHECK_EN - when defined, only the lane patterns
//            0001/0010/0100/1000/0011/1100/1111 are written; any other
//            non-zero pattern raises addr_err and is suppressed.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [2:0]          r_cnt;
  logic [2:0]          w_nextCnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_we;
  logic [31:0]         r_wdata;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   w_reqIdx;
  logic [ADDR_W-1:0]   w_rdIdx;
  logic                w_isRead;
  logic                w_illegal;
  logic                w_unusedAddrBits;

  // Upper bits alias and the byte offset does not select a word.
  assign w_reqIdx         = req_addr[ADDR_W+1:2];
  assign w_unusedAddrBits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

  // With LATENCY=1 DONE is entered straight from IDLE, so the read word must
  // come from the live request rather than from the not-yet-latched copy.
  assign w_rdIdx  = (r_state == IDLE) ? w_reqIdx : r_addr;
  assign w_isRead = (r_state == IDLE) ? (req_we == 4'b0000) : (r_we == 4'b0000);

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    w_illegal = 1'b1;
    case (r_we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_illegal = 1'b0;
      default:                   w_illegal = 1'b1;
    endcase
  end
`else
  assign w_illegal = 1'b0;
`endif

  // Next-state and counter logic
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_en) begin
          if (LATENCY == 1) begin
            w_nextState = DONE;
          end else begin
            w_nextState = WAIT;
            w_nextCnt   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        w_nextCnt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      rdata   <= 32'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (r_state == IDLE && req_en) begin
        r_addr  <= w_reqIdx;
        r_we    <= req_we;
        r_wdata <= req_wdata;
      end
      // Read data is captured on entry to DONE; writes leave rdata alone.
      if (w_nextState == DONE && r_state != DONE && w_isRead) begin
        rdata <= r_mem[w_rdIdx];
      end
    end
  end

  // Write commits on the edge that ends DONE; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (rst && r_state == DONE && !w_illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (r_we[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign resp_valid = rst && (r_state == DONE);
  assign addr_err   = rst && (r_state == DONE) && w_illegal;
  assign busy       = rst && ((r_state == WAIT) || (r_state == IDLE && req_en));

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Drives a LATENCY=2 and a
//            LATENCY=1 instance (ADDR_W=12) and compares every response with
//            a word-level reference memory held in associative arrays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_en;
  logic        sel;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;

  logic [31:0] rdata0, rdata1;
  logic        resp0, resp1, busy0, busy1, err0, err1;
  logic        req_en0, req_en1;

  logic [31:0] obsRdata;
  logic        obsResp, obsBusy, obsErr;

  int total = 0;
  int bad   = 0;

  logic [31:0] m0 [int];
  logic [31:0] m1 [int];
  logic [31:0] expR [2];
  int          pool [8];

  assign req_en0  = req_en & ~sel;
  assign req_en1  = req_en & sel;
  assign obsRdata = sel ? rdata1 : rdata0;
  assign obsResp  = sel ? resp1  : resp0;
  assign obsBusy  = sel ? busy1  : busy0;
  assign obsErr   = sel ? err1   : err0;

  dmem_responder #(.ADDR_W(12), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_en(req_en0), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .rdata(rdata0),
    .resp_valid(resp0), .busy(busy0), .addr_err(err0)
  );

  dmem_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_en(req_en1), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .rdata(rdata1),
    .resp_valid(resp1), .busy(busy1), .addr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit isIllegal(input logic [3:0] we);
`ifdef DMEM_ALIGN_CHECK_EN
    return (we != 4'b0000) && !(we inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                           4'b0011, 4'b1100, 4'b1111});
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelRead(input bit s, input int idx);
    if (s) return m1.exists(idx) ? m1[idx] : 32'hxxxxxxxx;
    else   return m0.exists(idx) ? m0[idx] : 32'hxxxxxxxx;
  endfunction

  // One complete access: accept, wait out the latency, check the response,
  // then apply the write to the reference memory.
  task automatic access(input bit s, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd);
    int          lat;
    int          idx;
    bit          err;
    logic [31:0] w;
    lat = s ? 1 : 2;
    idx = int'((a >> 2) & 32'h0000_0FFF);
    err = isIllegal(we);
    @(posedge clk); #1;
    sel = s; req_en = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    @(negedge clk);
    check("accept_busy", {31'd0, obsBusy}, 32'd1);
    check("accept_resp", {31'd0, obsResp}, 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      // Scramble request inputs: the latched copy must be used.
      req_en = 1'b0; req_addr = $urandom; req_we = 4'($urandom); req_wdata = $urandom;
      @(negedge clk);
      if (k < lat) begin
        check("wait_busy", {31'd0, obsBusy}, 32'd1);
        check("wait_resp", {31'd0, obsResp}, 32'd0);
      end else begin
        check("done_resp", {31'd0, obsResp}, 32'd1);
        check("done_busy", {31'd0, obsBusy}, 32'd0);
        check("done_err",  {31'd0, obsErr},  {31'd0, err});
        if (we == 4'b0000) expR[s] = modelRead(s, idx);
        check(we == 4'b0000 ? "read_data" : "write_rdata_hold", obsRdata, expR[s]);
      end
    end
    if (we != 4'b0000 && !err) begin
      w = modelRead(s, idx);
      for (int b = 0; b < 4; b++) begin
        if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
      end
      if (s) m1[idx] = w; else m0[idx] = w;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  we;
    bit          s;

    rst = 1'b0; req_en = 1'b1; sel = 1'b0;
    req_addr = 32'h10; req_we = 4'hF; req_wdata = 32'h1;
    expR[0] = 32'd0; expR[1] = 32'd0;

    // Reset held two cycles with a request pending
    repeat (2) begin
      @(negedge clk);
      check("rst_busy0", {31'd0, busy0}, 32'd0);
      check("rst_busy1", {31'd0, busy1}, 32'd0);
    end
    check("rst_resp0",  {31'd0, resp0}, 32'd0);
    check("rst_err0",   {31'd0, err0},  32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    req_en = 1'b0; rst = 1'b1;

    // Full write then readback
    access(0, 32'h10, 4'b1111, 32'hDEADBEEF);
    access(0, 32'h10, 4'b0000, 32'h0);
    check("rd_deadbeef", expR[0], 32'hDEADBEEF);
    // Single-lane write
    access(0, 32'h10, 4'b0010, 32'h0000AB00);
    access(0, 32'h10, 4'b0000, 32'h0);
    check("rd_lane1", expR[0], 32'hDEADABEF);
    // Aliased address
    access(0, 32'h4010, 4'b0000, 32'h0);
    check("rd_alias", expR[0], 32'hDEADABEF);
    // LATENCY=1 instance
    access(1, 32'h20, 4'b1111, 32'hCAFEF00D);
    access(1, 32'h23, 4'b0000, 32'h0);
    check("rd_lat1", expR[1], 32'hCAFEF00D);

    // Reset during WAIT drops the pending write
    @(posedge clk); #1;
    sel = 1'b0; req_en = 1'b1; req_addr = 32'h10; req_we = 4'hF; req_wdata = 32'h12345678;
    @(negedge clk);
    check("drop_accept_busy", {31'd0, busy0}, 32'd1);
    @(posedge clk); #1;
    req_en = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("drop_rst_busy", {31'd0, busy0}, 32'd0);
    check("drop_rst_resp", {31'd0, resp0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; expR[0] = 32'd0; expR[1] = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check("drop_no_resp", {31'd0, resp0}, 32'd0);
      check("drop_rdata0",  rdata0, 32'd0);
    end
    access(0, 32'h10, 4'b0000, 32'h0);
    check("rd_after_drop", expR[0], 32'hDEADABEF);

    // Non-contiguous lane pattern
    access(0, 32'h10, 4'b0110, 32'hFFFFFFFF);
    access(0, 32'h10, 4'b0000, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("rd_0110", expR[0], 32'hDEADABEF);
`else
    check("rd_0110", expR[0], 32'hDEFFFFEF);
`endif

    // Randomized traffic over a small pool of words on both instances
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(0, 4095));
      for (int d = 0; d < 2; d++) begin
        access(d[0], 32'(pool[i]) << 2, 4'hF, $urandom);
      end
    end
    for (int n = 0; n < 60; n++) begin
      s  = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFFF_C003) | (32'(pool[$urandom_range(0, 7)]) << 2);
      we = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      access(s, a, we, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
